// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the pipelined adder/subtractor:
//   - operation encoding for the 'sub' control bit
//   - pipeline depth derived from operand width and slice width
//   - saturation limits (largest positive / most negative two's-complement
//     value) for a given width, used when PIPELINED_ADD_SUB_SAT_EN is defined
// -----------------------------------------------------------------------------
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // One pipeline stage per SLICE-bit chunk of the carry chain.
    function automatic int stages_f(input int width, input int slice);
        return width / slice;
    endfunction

    // 0x7F..F for the given width, right-aligned in 64 bits.
    function automatic logic [63:0] sat_max_f(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    // 0x80..0 for the given width, right-aligned in 64 bits.
    function automatic logic [63:0] sat_min_f(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/pipelined_add_sub_if.sv
// -----------------------------------------------------------------------------
// pipelined_add_sub_if
// Operand/result handshake bundle for pipelined_add_sub.
//   in_valid/in_ready : operand beat handshake (a, b, sub travel with it)
//   out_valid/out_ready : result beat handshake (sum, cout, ovf, zero)
// Modports:
//   master : operand source / result consumer side
//   slave  : the adder/subtractor itself
// -----------------------------------------------------------------------------
interface pipelined_add_sub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );

endinterface

// File: rtl/add_sub_slice.sv
// -----------------------------------------------------------------------------
// add_sub_slice
// Combinational SLICE-bit adder used for one pipeline stage of the carry chain.
// Ports:
//   i_a, i_b  : slice operands (i_b already inverted for subtraction)
//   i_c       : carry in from the previous slice (or 'sub' for slice 0)
//   o_s       : slice sum
//   o_c       : carry out of the slice MSB
//   o_c_msb   : carry into the slice MSB (only meaningful for the top slice,
//               where it feeds the signed-overflow flag)
// -----------------------------------------------------------------------------
module add_sub_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] i_a,
    input  logic [SLICE-1:0] i_b,
    input  logic             i_c,
    output logic [SLICE-1:0] o_s,
    output logic             o_c,
    output logic             o_c_msb
);

    logic [SLICE:0] w_full;

    assign w_full  = {1'b0, i_a} + {1'b0, i_b} + {{SLICE{1'b0}}, i_c};
    assign o_s     = w_full[SLICE-1:0];
    assign o_c     = w_full[SLICE];
    // Sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out directly.
    assign o_c_msb = i_a[SLICE-1] ^ i_b[SLICE-1] ^ w_full[SLICE-1];

endmodule

// File: rtl/pipelined_add_sub.sv
// -----------------------------------------------------------------------------
// pipelined_add_sub
// Pipelined two's-complement adder/subtractor. The WIDTH-bit carry chain is cut
// into STAGES = WIDTH/SLICE slices, one slice resolved per pipeline stage; the
// already-resolved low result bits and the not-yet-added high operand bits ride
// along in the stage registers. Latency STAGES cycles, one beat per cycle.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears all valid bits and outputs)
//   bus   : pipelined_add_sub_if.slave -- operand and result handshakes
// Build option:
//   PIPELINED_ADD_SUB_SAT_EN : when defined, overflowing results saturate to
//                              0x7F..F / 0x80..0 (sign taken from A);
//                              otherwise results wrap modulo 2^WIDTH.
// -----------------------------------------------------------------------------
module pipelined_add_sub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    pipelined_add_sub_if.slave  bus
);

    localparam int STAGES = stages_f(WIDTH, SLICE);
    localparam int LAST   = STAGES - 1;

    if (WIDTH % SLICE != 0) begin : g_bad_cfg
        $error("pipelined_add_sub: WIDTH must be a multiple of SLICE");
    end

    // Per-stage inputs (from the bus for stage 0, from the previous register otherwise)
    logic [STAGES-1:0] w_vld_in;
    logic [WIDTH-1:0]  w_a_in   [STAGES];
    logic [WIDTH-1:0]  w_bx_in  [STAGES];
    logic [WIDTH-1:0]  w_s_in   [STAGES];
    logic              w_c_in   [STAGES];

    // Per-stage combinational results
    logic [SLICE-1:0]  w_slice_s [STAGES];
    logic              w_slice_c [STAGES];
    logic              w_slice_cm[STAGES];
    logic [WIDTH-1:0]  w_s_out   [STAGES];

    // Inter-stage registers (element LAST is the output stage and uses r_sum etc.)
    logic [STAGES-1:0] r_vld_p;
    logic [WIDTH-1:0]  r_a_p  [STAGES];
    logic [WIDTH-1:0]  r_bx_p [STAGES];
    logic [WIDTH-1:0]  r_s_p  [STAGES];
    logic              r_c_p  [STAGES];

    // Output registers
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;
    logic              r_ovf;
    logic              r_zero;

    logic              w_adv;
    logic              w_ovf;
    logic [WIDTH-1:0]  w_sum_fin;

    // Single global enable: the whole pipe moves unless a result is parked.
    assign w_adv = !r_vld_p[LAST] || bus.out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign w_vld_in[k] = bus.in_valid;
            assign w_a_in[k]   = bus.a;
            assign w_bx_in[k]  = (bus.sub == OP_SUB) ? ~bus.b : bus.b;
            assign w_c_in[k]   = bus.sub;
            assign w_s_in[k]   = '0;
        end else begin : g_next
            assign w_vld_in[k] = r_vld_p[k-1];
            assign w_a_in[k]   = r_a_p[k-1];
            assign w_bx_in[k]  = r_bx_p[k-1];
            assign w_c_in[k]   = r_c_p[k-1];
            assign w_s_in[k]   = r_s_p[k-1];
        end

        add_sub_slice #(
            .SLICE (SLICE)
        ) u_slice (
            .i_a     (w_a_in[k][k*SLICE +: SLICE]),
            .i_b     (w_bx_in[k][k*SLICE +: SLICE]),
            .i_c     (w_c_in[k]),
            .o_s     (w_slice_s[k]),
            .o_c     (w_slice_c[k]),
            .o_c_msb (w_slice_cm[k])
        );

        // Partial sum is built up from zero, so the slice bits can simply be OR-ed in.
        assign w_s_out[k] = w_s_in[k] | (WIDTH'(w_slice_s[k]) << (k * SLICE));
    end

    assign w_ovf = w_slice_c[LAST] ^ w_slice_cm[LAST];

`ifdef PIPELINED_ADD_SUB_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max_f(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min_f(WIDTH));

    // On overflow both operands (after B inversion) share A's sign, so A's sign
    // is the sign of the true result.
    function automatic logic [WIDTH-1:0] sat_f(input logic [WIDTH-1:0] raw,
                                               input logic             ovf,
                                               input logic             neg);
        if (!ovf) begin
            return raw;
        end
        return neg ? SAT_MIN : SAT_MAX;
    endfunction

    assign w_sum_fin = sat_f(w_s_out[LAST], w_ovf, w_a_in[LAST][WIDTH-1]);
`else
    assign w_sum_fin = w_s_out[LAST];
`endif

    // ---- stage valid bits ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p <= '0;
        end else if (w_adv) begin
            r_vld_p <= w_vld_in;
        end
    end

    // ---- stages 0 .. STAGES-2 : partial sum, carry and remaining operands ----
    always_ff @(posedge clk) begin
        if (w_adv) begin
            for (int k = 0; k < LAST; k++) begin
                if (w_vld_in[k]) begin
                    r_a_p[k]  <= w_a_in[k];
                    r_bx_p[k] <= w_bx_in[k];
                    r_s_p[k]  <= w_s_out[k];
                    r_c_p[k]  <= w_slice_c[k];
                end
            end
        end
    end

    // ---- final stage : result and flags ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_adv && w_vld_in[LAST]) begin
            r_sum  <= w_sum_fin;
            r_cout <= w_slice_c[LAST];
            r_ovf  <= w_ovf;
            r_zero <= (w_sum_fin == '0);
        end
    end

    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_vld_p[LAST];
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;
    assign bus.zero      = r_zero;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// -----------------------------------------------------------------------------
// tb_pipelined_add_sub
// Self-checking bench for pipelined_add_sub (WIDTH=16, SLICE=4). Expected
// results come from a plain-arithmetic reference model held in a queue in
// acceptance order. Honours PIPELINED_ADD_SUB_SAT_EN for expected sums.
// -----------------------------------------------------------------------------
module tb_pipelined_add_sub;
    import addsub_pkg::*;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    logic clk;
    logic rst_n;

    pipelined_add_sub_if #(.WIDTH(W)) bus ();

    pipelined_add_sub #(.WIDTH(W), .SLICE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   n_pop = 0;
    res_t q[$];

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        res_t        r;
        int          sa;
        int          sb;
        int          t;
        logic [W:0]  u;
        sa = $signed(a);
        sb = $signed(b);
        t  = (s == OP_SUB) ? sa - sb : sa + sb;
        u  = (s == OP_SUB) ? ({1'b0, a} + {1'b0, ~b} + 17'd1) : ({1'b0, a} + {1'b0, b});
        r.cout = u[W];
        r.ovf  = (t > 32767) || (t < -32768);
        r.sum  = u[W-1:0];
`ifdef PIPELINED_ADD_SUB_SAT_EN
        if (r.ovf) r.sum = (t > 0) ? 16'h7FFF : 16'h8000;
`endif
        r.zero = (r.sum == '0);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: record accepted beats into the model, check handshaked results.
    task automatic tick();
        res_t e;
        if (bus.in_valid && bus.in_ready)
            q.push_back(model(bus.a, bus.b, bus.sub));
        if (bus.out_valid && bus.out_ready) begin
            chk("result_expected", (q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                n_pop++;
                chk("sum",  bus.sum,  e.sum);
                chk("cout", bus.cout, e.cout);
                chk("ovf",  bus.ovf,  e.ovf);
                chk("zero", bus.zero, e.zero);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic s, input logic [W-1:0] es, input logic ec,
                            input logic eo, input logic ez);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.sub      = s;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            chk({tag, "_early_valid"}, bus.out_valid, 0);
            tick();
        end
        chk({tag, "_valid_at_4"}, bus.out_valid, 1);
        chk({tag, "_sum"},  bus.sum,  es);
        chk({tag, "_cout"}, bus.cout, ec);
        chk({tag, "_ovf"},  bus.ovf,  eo);
        chk({tag, "_zero"}, bus.zero, ez);
        tick();
    endtask

    task automatic drain(input string tag);
        int guard;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        guard = 0;
        while (q.size() != 0 && guard < 20) begin
            tick();
            guard++;
        end
        chk({tag, "_drained"}, q.size(), 0);
    endtask

    initial begin
        int          n0;
        int          cyc;
        int          guard;
        int          n_stall;
        logic        acc;
        logic        stall;
        logic [W-1:0] held;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready",  bus.in_ready,  1);
        chk("rst_sum",       bus.sum,       0);
        chk("rst_flags",     {bus.cout, bus.ovf, bus.zero}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1);

        // Directed arithmetic
        directed("add_basic", 16'h1234, 16'h1111, OP_ADD, 16'h2345, 1'b0, 1'b0, 1'b0);
        directed("sub_borrow", 16'h0005, 16'h0007, OP_SUB, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        directed("sub_zero", 16'h1234, 16'h1234, OP_SUB, 16'h0000, 1'b1, 1'b0, 1'b1);
`ifdef PIPELINED_ADD_SUB_SAT_EN
        directed("add_ovf", 16'h7FFF, 16'h0001, OP_ADD, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        directed("sub_ovf", 16'h8000, 16'h0001, OP_SUB, 16'h8000, 1'b1, 1'b1, 1'b0);
`else
        directed("add_ovf", 16'h7FFF, 16'h0001, OP_ADD, 16'h8000, 1'b0, 1'b1, 1'b0);
        directed("sub_ovf", 16'h8000, 16'h0001, OP_SUB, 16'h7FFF, 1'b1, 1'b1, 1'b0);
`endif

        // Random full-rate stream
        n0 = n_pop;
        for (int i = 0; i < 100; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = W'($urandom);
            bus.b        = W'($urandom);
            bus.sub      = 1'($urandom_range(0, 1));
            tick();
            if (i >= 3) chk("stream_out_valid", bus.out_valid, 1);
        end
        drain("stream");
        chk("stream_count", n_pop - n0, 100);

        // Back-pressure: out_ready low for 6 cycles mid-stream
        n0      = n_pop;
        cyc     = 0;
        n_stall = 0;
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = W'($urandom);
            bus.b        = W'($urandom);
            bus.sub      = 1'($urandom_range(0, 1));
            guard = 0;
            do begin
                bus.out_ready = !(cyc >= 8 && cyc < 14);
                #1;
                acc   = bus.in_ready;
                stall = bus.out_valid && !bus.out_ready;
                held  = bus.sum;
                if (stall) begin
                    n_stall++;
                    chk("stall_in_ready", bus.in_ready, 0);
                end
                tick();
                cyc++;
                guard++;
                if (stall) begin
                    chk("stall_sum_hold",  bus.sum,       held);
                    chk("stall_out_valid", bus.out_valid, 1);
                end
            end while (!acc && guard < 40);
            if (!acc) chk("stall_accept_timeout", acc, 1);
        end
        chk("stall_cycles", n_stall, 6);
        drain("stall");
        chk("stall_count", n_pop - n0, 20);

        // Asynchronous reset with beats in flight
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = W'($urandom);
            bus.b        = W'($urandom);
            bus.sub      = 1'($urandom_range(0, 1));
            tick();
        end
        chk("pre_rst_out_valid", bus.out_valid, 1);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_in_ready",  bus.in_ready,  1);
        chk("midrst_sum",       bus.sum,       0);
        chk("midrst_flags",     {bus.cout, bus.ovf, bus.zero}, 0);
        q.delete();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        directed("after_rst", 16'h0F0F, 16'h00FF, OP_SUB, 16'h0E10, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            chk("after_rst_no_stale", bus.out_valid, 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipelined_add_sub.md
# pipelined_add_sub

Parametrised, pipelined two's-complement adder/subtractor with valid/ready handshaking and status flags. It generalises the 4-bit ripple add/sub datapath to any WIDTH and splits the carry chain into SLICE-bit pipeline stages, so long operands still close timing. It sits between an operand source and a result consumer in the arithmetic datapath and accepts one operation per cycle when not back-pressured.

## Interface
- WIDTH, 16: operand/result width in bits; must be a multiple of SLICE.
- SLICE, 4: bits resolved per pipeline stage; STAGES = WIDTH/SLICE.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0 = A+B, 1 = A−B.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB (for subtract: 1 = no borrow).
- ovf  out  1  signed overflow.
- zero  out  1  sum == 0.

## Operation
- Subtract: B is XORed with sub, and sub is the carry-in of slice 0 (A + ~B + 1).
- Stage k adds bits [k·SLICE +: SLICE] using the carry registered from stage k−1. The lower, already-resolved result bits and the upper, not-yet-added operand bits travel alongside in pipeline registers.
- Each stage register holds one valid bit. A beat is accepted when in_valid && in_ready.
- Global stall: all stages hold while out_valid && !out_ready. in_ready = !out_valid || out_ready, evaluated combinationally.
- Flags are computed in the final stage:
  - cout = carry out of bit WIDTH−1.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = (final sum == 0).
- Arithmetic is modulo 2^WIDTH unless saturation is compiled in (see Configuration).
- Bubbles (in_valid = 0) propagate as invalid stages. They never stall the pipe.

## Timing
- Latency: a beat accepted in cycle t presents out_valid in cycle t+STAGES, provided no stall occurs.
- Throughput: one beat per cycle.
- Reset, which is asynchronous and may arrive mid-operation:
  - All valid bits clear immediately. In-flight beats are discarded.
  - sum, cout, ovf and zero reset to 0. out_valid resets to 0.
  - in_ready reads 1 while rst_n is low and after reset.
- Outputs are registered. sum and flags hold stable while out_valid && !out_ready.
- Simultaneous output handshake and new input in the same cycle is legal. The pipe advances and no beat is lost or duplicated.
- sub is sampled with its beat. Mixed add/sub beats back-to-back are legal.

## Configuration
- Macro: PIPELINED_ADD_SUB_SAT_EN.
- When defined:
  - If ovf = 1, sum saturates to 0x7F…F when the true result is positive, or 0x80…0 when it is negative. The sign of the true result is taken from A's sign.
  - ovf still reports 1. zero is computed on the saturated value.
- When undefined: sum wraps modulo 2^WIDTH. No saturation logic is present.

## Structure
- Shared package addsub_pkg holds:
  - op encoding constants OP_ADD = 1'b0 and OP_SUB = 1'b1.
  - a function returning STAGES from WIDTH and SLICE.
  - the saturation limit constants, expressed as functions of WIDTH.
- One sub-module, add_sub_slice: a combinational SLICE-bit adder with carry-in, carry-out and the carry into its MSB, used for the overflow computation. It is instantiated STAGES times. Pipeline registers, handshake logic and flags stay in the top module.
- An elaboration-time check rejects configurations where WIDTH % SLICE != 0.

## Test plan
All scenarios use WIDTH = 16, SLICE = 4.
- a = 0x1234, b = 0x1111, sub = 0 → sum 0x2345, cout 0, ovf 0, zero 0; out_valid exactly 4 cycles after acceptance.
- a = 0x0005, b = 0x0007, sub = 1 → sum 0xFFFE, cout 0 (borrow), ovf 0. Then a = b = 0x1234, sub = 1 → sum 0x0000, zero 1, cout 1.
- a = 0x7FFF, b = 0x0001, sub = 0 → ovf 1. Without the macro, sum 0x8000; with PIPELINED_ADD_SUB_SAT_EN, sum 0x7FFF. Then a = 0x8000, b = 0x0001, sub = 1 → with the macro, sum 0x8000 and ovf 1.
- Stream 100 random beats with in_valid = 1 and out_ready = 1 → one result per cycle, in order, matching the reference model.
- Hold out_ready = 0 for 6 cycles while streaming → in_ready drops once out_valid = 1; sum holds stable. On release, no beat is lost or duplicated.
- Assert rst_n low mid-stream with 3 beats in flight → out_valid goes to 0 immediately, all outputs read 0, and the next accepted beat emerges 4 cycles later with the correct result.
